// File: rtl/sp1_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Operands arrive and results leave over independent valid/ready handshakes.
module sp1_div #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          dz
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_dvd;
  logic [DW-1:0] r_dsr;
  logic [DW-1:0] r_quot;
  logic [DW:0]   r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [DW-1:0] r_quotient;
  logic [DW-1:0] r_remainder;
  logic          r_dz;

  logic [DW:0]   w_shift;
  logic [DW+1:0] w_sub;
  logic          w_borrow;
  logic [DW:0]   w_rem_next;
  logic [DW-1:0] w_quot_next;
  logic          w_last;

  // Partial remainder stays below the divisor, so the shifted value fits DW+1 bits.
  assign w_shift     = {r_rem[DW-1:0], r_dvd[DW-1]};
  assign w_sub       = {1'b0, w_shift} - {2'b00, r_dsr};
  assign w_borrow    = w_sub[DW+1];
  assign w_rem_next  = w_borrow ? w_shift : w_sub[DW:0];
  assign w_quot_next = {r_quot[DW-2:0], ~w_borrow};
  assign w_last      = (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = CALC;
      CALC:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == IDLE);
      r_out_valid <= (w_state_next == DONE);
    end
  end

  // Result registers change only at acceptance (dz) and at the final CALC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd  <= dividend;
            r_dsr  <= divisor;
            r_rem  <= '0;
            r_quot <= '0;
            r_cnt  <= CW'(DW - 1);
            r_dz   <= (divisor == '0);
          end
        end
        CALC: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_dvd  <= {r_dvd[DW-2:0], 1'b0};
          if (w_last) begin
            r_quotient  <= w_quot_next;
            r_remainder <= w_rem_next[DW-1:0];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign dz        = r_dz;

endmodule

// File: tb/tb_sp1_div.sv
// Randomized self-checking bench for sp1_div against an arithmetic reference model.
module tb_sp1_div;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          dz;

  int n_checks = 0;
  int n_errors = 0;

  sp1_div #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_q(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b == 0) ? {DW{1'b1}} : a / b;
  endfunction

  function automatic logic [DW-1:0] model_r(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".in_ready"},  in_ready,  1);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".quotient"},  quotient,  0);
    check({tag, ".remainder"}, remainder, 0);
    check({tag, ".dz"},        dz,        0);
  endtask

  // Present operands until accepted, then scramble the inputs to prove they were latched.
  task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept.in_ready", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = DW'($urandom);
    check("accept.taken", in_ready, 0);
  endtask

  // Wait for the result, check latency/values/hold, then complete the output handshake.
  task automatic finish(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold,
                        input logic nxt_valid, input logic [DW-1:0] na, input logic [DW-1:0] nb);
    int lat = 0;
    logic [DW-1:0] eq = model_q(a, b);
    logic [DW-1:0] er = model_r(a, b);
    out_ready = (hold == 0);
    while (!out_valid && lat <= DW + 4) begin
      if (in_ready) check("calc.in_ready", in_ready, 0);
      in_valid = 1'($urandom);
      dividend = DW'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, DW);
    check("result.quotient", quotient, eq);
    check("result.remainder", remainder, er);
    check("result.dz", dz, (b == 0));
    check("done.in_ready", in_ready, 0);
    $display("txn %04h / %04h -> q=%04h r=%04h dz=%0d lat=%0d hold=%0d", a, b, quotient, remainder, dz, lat, hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold.out_valid", out_valid, 1);
      check("hold.quotient", quotient, eq);
      check("hold.remainder", remainder, er);
      check("hold.in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = nxt_valid;
    dividend  = na;
    divisor   = nb;
    tick();
    check("release.out_valid", out_valid, 0);
    check("release.in_ready", in_ready, 1);
    if (nxt_valid) begin
      tick();
      check("b2b.accepted", in_ready, 0);
      in_valid = 1'b0;
      dividend = DW'($urandom);
      divisor  = DW'($urandom);
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
    accept(a, b);
    finish(a, b, hold, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check_reset_state("reset");

    run_op(16'h0064, 16'h0007, 0);
    run_op(16'hffff, 16'h0001, 0);
    run_op(16'h0003, 16'h000a, 0);
    run_op(16'h0005, 16'h0000, 0);
    run_op(16'h0000, 16'h0009, 1);
    run_op(16'h0000, 16'h0000, 0);
    run_op(16'h0064, 16'h0007, 10);
    run_op(16'hffff, 16'hffff, 0);
    run_op(16'h8000, 16'hffff, 2);

    // Result handshake with in_valid already high: new operands taken one edge later.
    accept(16'h0064, 16'h0007);
    finish(16'h0064, 16'h0007, 0, 1'b1, 16'h1234, 16'h0011);
    finish(16'h1234, 16'h0011, 0, 1'b0, '0, '0);

    // Reset in the middle of CALC abandons the operation.
    accept(16'h1234, 16'h0011);
    repeat (7) tick();
    check("mid.out_valid", out_valid, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    dividend = 16'h0064;
    divisor  = 16'h0007;
    tick();
    check_reset_state("rst_calc");
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check("rst_wins.in_ready", in_ready, 1);
    check("rst_wins.out_valid", out_valid, 0);
    run_op(16'h1234, 16'h0011, 0);

    // Reset while a result is being held.
    accept(16'h00ff, 16'h0010);
    out_ready = 1'b0;
    repeat (DW + 2) tick();
    check("rst_done.pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_done");

    for (int t = 0; t < 40; t++) begin
      logic [DW-1:0] a, b;
      a = DW'($urandom);
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = DW'($urandom_range(1, 15));
        2: b = a + DW'($urandom_range(0, 3));
        default: b = DW'($urandom);
      endcase
      run_op(a, b, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
